// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multu/divu sequencer holding HI/LO; stalls the core while an op is in flight.
// Optional macro MULDIV_EARLY_TERM_EN: multiply finishes once no multiplier bits remain.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;

  logic               is_mul, is_div, b_zero, accept, mul_skip;
  logic               mul_last, div_last;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier, divisor, rem, quo, rem_nxt, quo_nxt;
  logic [WIDTH:0]     rem_sh, trial;

  assign is_mul = (op == 2'd1);
  assign is_div = (op == 2'd2);
  assign b_zero = (src_b == '0);
  assign accept = start && (is_mul || is_div) && (state == S_IDLE || state == S_DONE);

`ifdef MULDIV_EARLY_TERM_EN
  assign mul_skip = b_zero;
  assign mul_last = (cnt == LAST) || (mplier[WIDTH-1:1] == '0);
`else
  assign mul_skip = 1'b0;
  assign mul_last = (cnt == LAST);
`endif
  assign div_last = (cnt == LAST);

  // One shift-add step and one restoring-divide step; trial[WIDTH] is the borrow.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, divisor};
  assign rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (is_div) state_nxt = b_zero ? S_DONE : S_DIV;
          else        state_nxt = mul_skip ? S_DONE : S_MUL;
        end
      end
      S_MUL:   if (mul_last) state_nxt = S_DONE;
      S_DIV:   if (div_last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == S_MUL) || (state == S_DIV);
    done  = (state == S_DONE);
    stall = busy || accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
    end else if (accept) begin
      cnt     <= '0;
      mcand   <= {{WIDTH{1'b0}}, src_a};
      acc     <= '0;
      mplier  <= src_b;
      divisor <= src_b;
      rem     <= '0;
      quo     <= src_a;
    end else if (state == S_MUL) begin
      cnt    <= cnt + 1'b1;
      acc    <= acc_nxt;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      cnt <= cnt + 1'b1;
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  // HI/LO change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (accept && is_div && b_zero) begin
      hi <= src_a;
      lo <= '1;
    end else if (accept && is_mul && mul_skip) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_MUL && mul_last) begin
      {hi, lo} <= acc_nxt;
    end else if (state == S_DIV && div_last) begin
      hi <= rem_nxt;
      lo <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: per-cycle arithmetic model plus directed literal vectors.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         stall, busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_cyc = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mul_iters(input logic [W-1:0] b);
    int n;
`ifdef MULDIV_EARLY_TERM_EN
    n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  // Model: result computed with plain * / %, plus the cycle it must appear in.
  logic         m_active = 1'b0;
  int           m_done_at = -1;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_busy, m_valid;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active  = 1'b0;
      m_done_at = -1;
      m_hi      = '0;
      m_lo      = '0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
    end else begin
      if (cyc == m_done_at) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      m_busy  = m_active && (cyc < m_done_at);
      m_valid = start && (op == 2'd1 || op == 2'd2);
      check("mdl_busy", busy, m_busy);
      check("mdl_done", done, cyc == m_done_at);
      check("mdl_stall", stall, m_busy || m_valid);
      check("mdl_hi", hi, m_hi);
      check("mdl_lo", lo, m_lo);
      if (m_valid && !m_busy) begin
        m_active = 1'b1;
        if (op == 2'd1) begin
          {p_hi, p_lo} = 64'(src_a) * 64'(src_b);
          m_done_at = cyc + 1 + mul_iters(src_b);
        end else if (src_b == '0) begin
          p_hi = src_a;
          p_lo = '1;
          m_done_at = cyc + 1;
        end else begin
          p_hi = src_a % src_b;
          p_lo = src_a / src_b;
          m_done_at = cyc + 1 + W;
        end
      end
    end
  end

  task automatic req(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    req_cyc = cyc;
    #1 check("req_stall", stall, (o == 2'd1 || o == 2'd2));
    @(posedge clk); #1;
    start = 1'b0; op = 2'd0;
  endtask

  task automatic wait_done(input string name, input int lat, input logic [W-1:0] eh, input logic [W-1:0] el);
    int got;
    got = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = cyc - req_cyc;
        break;
      end
    end
    check({name, "_lat"}, got, lat);
    if (got >= 0) begin
      check({name, "_hi"}, hi, eh);
      check({name, "_lo"}, lo, el);
      check({name, "_stall"}, stall, 0);
    end
  endtask

  task automatic expect_quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", stall, 0);
    check("reset_hi", hi, 0);
    rst_n = 1'b1;

    req(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_full", 33, 32'hFFFF_FFFE, 32'h0000_0001);

    req(2'd2, 32'd100, 32'd7);
    wait_done("div_100_7", 33, 32'd2, 32'd14);

    req(2'd2, 32'hFFFF_FFFF, 32'd1);
    wait_done("div_by_1", 33, 32'd0, 32'hFFFF_FFFF);

    req(2'd2, 32'h1234, 32'd0);
    wait_done("div_zero", 1, 32'h1234, 32'hFFFF_FFFF);

    req(2'd1, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul_2_32", 33, 32'd1, 32'd0);

    // A multu pulsed during a divide must be dropped.
    req(2'd2, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk); #1 start = 1'b0; op = 2'd0;
    wait_done("div_ignore", 33, 32'd1, 32'd333);
    expect_quiet("no_queued_mul", 5);

    @(posedge clk); #1 start = 1'b1; op = 2'd0; src_a = 32'd5; src_b = 32'd5;
    #1 check("op0_stall", stall, 0);
    op = 2'd3;
    #1 check("op3_stall", stall, 0);
    @(posedge clk); #1 start = 1'b0; op = 2'd0;
    expect_quiet("op_nop_quiet", 40);

    // Second request issued in the DONE cycle of the first.
    req(2'd2, 32'd50, 32'd8);
    repeat (32) @(posedge clk);
    #1 start = 1'b1; op = 2'd1; src_a = 32'd6; src_b = 32'd7;
    req_cyc = cyc;
    #4;
    check("chain_first_done", done, 1);
    check("chain_first_hi", hi, 32'd2);
    check("chain_first_lo", lo, 32'd6);
    check("chain_stall", stall, 1);
    @(posedge clk); #1 start = 1'b0; op = 2'd0;
    wait_done("chain_second", 33, 32'd0, 32'd42);

    req(2'd1, 32'h1234, 32'h5678);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_stall", stall, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_quiet("post_reset_quiet", 40);

`ifdef MULDIV_EARLY_TERM_EN
    req(2'd1, 32'd3, 32'd5);
    wait_done("mul_3_5", 4, 32'd0, 32'd15);
    req(2'd1, 32'd3, 32'd0);
    wait_done("mul_by_0", 1, 32'd0, 32'd0);
`else
    req(2'd1, 32'd3, 32'd5);
    wait_done("mul_3_5", 33, 32'd0, 32'd15);
    req(2'd1, 32'd3, 32'd0);
    wait_done("mul_by_0", 33, 32'd0, 32'd0);
`endif

    // Extra operand mixes checked by the per-cycle model only.
    for (int k = 0; k < 6; k++) begin
      int got;
      req((k % 2 == 0) ? 2'd1 : 2'd2, $urandom, (k == 3) ? 32'd0 : $urandom_range(1, 5000));
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (done) got = 1;
      end
      check("mix_done_seen", got, 1);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
